traffic_junction: RTL and testbench

Parametrised two-road junction controller, the successor to the single-head `lights` sequencer. It drives a main-road head, a side-road head and a pedestrian WALK signal. All dwell times are set by parameters, and the main road gets a minimum-green hold. It adds latched side-road and pedestrian demand plus a fault flash mode. It sits at the top of the traffic-light exercise and drives LED outputs directly.

---
 rtl/traffic_junction.sv | 197 +++++++++++++++++++
 tb/tb_traffic_junction.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/traffic_junction.sv
// rtl/traffic_junction.sv - two-road junction controller with demand latches, pedestrian phase and fault flash
//
// Purpose: sequences a main-road head, a side-road head and a pedestrian WALK
// lamp. Main green is held until side or pedestrian demand is latched after
// its minimum dwell. A pedestrian phase is inserted after either amber when
// requested. A fault forces both heads into amber flash.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   enable    0 freezes state, timer and outputs; demand latching and fault entry still act
//   side_req  side-road vehicle demand (level or pulse)
//   ped_req   pedestrian button (level or pulse)
//   fault     forces flash mode while high
//   main_rag  main head {red, amber, green}
//   side_rag  side head {red, amber, green}
//   ped_walk  WALK lamp
//   phase     current state code
module traffic_junction #(
  parameter int RA_T    = 2,
  parameter int GM_T    = 8,
  parameter int GS_T    = 6,
  parameter int AM_T    = 3,
  parameter int AR_T    = 1,
  parameter int PED_T   = 5,
  parameter int FLASH_T = 4,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       fault,
  output logic [2:0] main_rag,
  output logic [2:0] side_rag,
  output logic       ped_walk,
  output logic [3:0] phase
);

  typedef enum logic [3:0] {
    AR_M  = 4'd0,
    M_RA  = 4'd1,
    M_G   = 4'd2,
    M_AM  = 4'd3,
    AR_S  = 4'd4,
    S_RA  = 4'd5,
    S_G   = 4'd6,
    S_AM  = 4'd7,
    PED   = 4'd8,
    FLASH = 4'd9
  } state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_RA  = 3'b110;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_AMB = 3'b010;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             side_lat_q, side_lat_d;
  logic             ped_lat_q, ped_lat_d;
  logic             ped_to_side_q, ped_to_side_d;  // PED was entered from M_AM, so exit to AR_S
  logic             flash_on_q, flash_on_d;        // amber half of the flash period
  logic             side_dem, ped_dem, at_end;

  // Final timer value of each state's dwell; in FLASH it marks a half-period.
  function automatic logic [CNT_W-1:0] last_tick(input state_e s);
    case (s)
      M_RA, S_RA: last_tick = CNT_W'(RA_T - 1);
      M_G:        last_tick = CNT_W'(GM_T - 1);
      S_G:        last_tick = CNT_W'(GS_T - 1);
      M_AM, S_AM: last_tick = CNT_W'(AM_T - 1);
      PED:        last_tick = CNT_W'(PED_T - 1);
      FLASH:      last_tick = CNT_W'(FLASH_T - 1);
      default:    last_tick = CNT_W'(AR_T - 1);
    endcase
  endfunction

  // A request arriving this cycle counts as demand at this edge, matching
  // the latch becoming visible from the same edge.
  assign side_dem = side_lat_q | side_req;
  assign ped_dem  = ped_lat_q | ped_req;
  assign at_end   = (timer_q == last_tick(state_q));

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    flash_on_d    = flash_on_q;
    ped_to_side_d = ped_to_side_q;
    if (fault && state_q != FLASH) begin
      state_d    = FLASH;
      timer_d    = '0;
      flash_on_d = 1'b1;
    end else if (enable) begin
      if (state_q == FLASH) begin
        if (!fault) begin
          state_d = AR_M;
          timer_d = '0;
        end else if (at_end) begin
          timer_d    = '0;
          flash_on_d = ~flash_on_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end else if (state_q == M_G && at_end && !(side_dem || ped_dem)) begin
        timer_d = timer_q;  // main green held, timer saturated
      end else if (at_end) begin
        timer_d = '0;
        case (state_q)
          AR_M: state_d = M_RA;
          M_RA: state_d = M_G;
          M_G:  state_d = M_AM;
          M_AM: begin
            if (ped_dem) begin
              state_d       = PED;
              ped_to_side_d = 1'b1;
            end else begin
              state_d = AR_S;
            end
          end
          AR_S: state_d = S_RA;
          S_RA: state_d = S_G;
          S_G:  state_d = S_AM;
          S_AM: begin
            if (ped_dem) begin
              state_d       = PED;
              ped_to_side_d = 1'b0;
            end else begin
              state_d = AR_M;
            end
          end
          PED:     state_d = ped_to_side_q ? AR_S : AR_M;
          default: state_d = AR_M;
        endcase
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Clear on phase entry, then set, so a coincident request is retained.
  always_comb begin
    side_lat_d = side_lat_q;
    ped_lat_d  = ped_lat_q;
    if (state_d == S_G && state_q != S_G) side_lat_d = 1'b0;
    if (state_d == PED && state_q != PED) ped_lat_d = 1'b0;
    if (side_req) side_lat_d = 1'b1;
    if (ped_req)  ped_lat_d  = 1'b1;
    if (state_q == FLASH || state_d == FLASH) begin
      side_lat_d = 1'b0;
      ped_lat_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= AR_M;
      timer_q       <= '0;
      side_lat_q    <= 1'b0;
      ped_lat_q     <= 1'b0;
      ped_to_side_q <= 1'b0;
      flash_on_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      side_lat_q    <= side_lat_d;
      ped_lat_q     <= ped_lat_d;
      ped_to_side_q <= ped_to_side_d;
      flash_on_q    <= flash_on_d;
    end
  end

  always_comb begin
    main_rag = LAMP_RED;
    side_rag = LAMP_RED;
    ped_walk = 1'b0;
    case (state_q)
      M_RA:  main_rag = LAMP_RA;
      M_G:   main_rag = LAMP_GRN;
      M_AM:  main_rag = LAMP_AMB;
      S_RA:  side_rag = LAMP_RA;
      S_G:   side_rag = LAMP_GRN;
      S_AM:  side_rag = LAMP_AMB;
      PED:   ped_walk = 1'b1;
      FLASH: begin
        main_rag = flash_on_q ? LAMP_AMB : LAMP_OFF;
        side_rag = flash_on_q ? LAMP_AMB : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_junction.sv
// tb/tb_traffic_junction.sv - randomized self-checking bench for traffic_junction
module tb_traffic_junction;

  localparam int RA_T = 2, GM_T = 4, GS_T = 3, AM_T = 2, AR_T = 1, PED_T = 3, FLASH_T = 2, CNT_W = 8;
  localparam int ST_ARM = 0, ST_MRA = 1, ST_MG = 2, ST_MAM = 3, ST_ARS = 4;
  localparam int ST_SRA = 5, ST_SG = 6, ST_SAM = 7, ST_PED = 8, ST_FLASH = 9;

  logic       clk = 1'b0;
  logic       rst, enable, side_req, ped_req, fault;
  logic [2:0] main_rag, side_rag;
  logic       ped_walk;
  logic [3:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: named phase, cycles spent in it, pending demands.
  int m_st, m_age;
  bit m_side, m_ped, m_ped_from_main;

  traffic_junction #(
    .RA_T(RA_T), .GM_T(GM_T), .GS_T(GS_T), .AM_T(AM_T), .AR_T(AR_T),
    .PED_T(PED_T), .FLASH_T(FLASH_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .side_req(side_req), .ped_req(ped_req),
    .fault(fault), .main_rag(main_rag), .side_rag(side_rag), .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dwell(input int st);
    case (st)
      ST_MRA, ST_SRA: return RA_T;
      ST_SG:          return GS_T;
      ST_MAM, ST_SAM: return AM_T;
      ST_PED:         return PED_T;
      default:        return AR_T;
    endcase
  endfunction

  task automatic model_reset();
    m_st = ST_ARM; m_age = 0; m_side = 0; m_ped = 0; m_ped_from_main = 0;
  endtask

  // Advance the model across one clock edge given the inputs held before it.
  task automatic model_step(input bit s, input bit p, input bit en, input bit f);
    int old;
    bit pd;
    old = m_st;
    pd  = m_ped | p;
    if (f && m_st != ST_FLASH) begin
      m_st = ST_FLASH; m_age = 0;
    end else if (en) begin
      if (m_st == ST_FLASH) begin
        if (!f) begin m_st = ST_ARM; m_age = 0; end
        else m_age++;
      end else if (m_st == ST_MG) begin
        if (m_age >= GM_T - 1 && (m_side || s || pd)) begin m_st = ST_MAM; m_age = 0; end
        else m_age++;
      end else if (m_age + 1 >= dwell(m_st)) begin
        case (m_st)
          ST_MAM:  m_st = pd ? ST_PED : ST_ARS;
          ST_SAM:  m_st = pd ? ST_PED : ST_ARM;
          ST_PED:  m_st = m_ped_from_main ? ST_ARS : ST_ARM;
          default: m_st = m_st + 1;
        endcase
        if (m_st == ST_PED) m_ped_from_main = (old == ST_MAM);
        m_age = 0;
      end else m_age++;
    end
    if (m_st == ST_SG && old != ST_SG) m_side = 0;
    if (m_st == ST_PED && old != ST_PED) m_ped = 0;
    if (s) m_side = 1;
    if (p) m_ped = 1;
    if (old == ST_FLASH || m_st == ST_FLASH) begin m_side = 0; m_ped = 0; end
  endtask

  task automatic compare_all(input string ctx);
    logic [2:0] em, es;
    logic       ew;
    em = 3'b100; es = 3'b100; ew = 1'b0;
    case (m_st)
      ST_MRA: em = 3'b110;
      ST_MG:  em = 3'b001;
      ST_MAM: em = 3'b010;
      ST_SRA: es = 3'b110;
      ST_SG:  es = 3'b001;
      ST_SAM: es = 3'b010;
      ST_PED: ew = 1'b1;
      ST_FLASH: begin
        em = ((m_age / FLASH_T) % 2 == 0) ? 3'b010 : 3'b000;
        es = em;
      end
      default: ;
    endcase
    check({ctx, ".main"}, 32'(main_rag), 32'(em));
    check({ctx, ".side"}, 32'(side_rag), 32'(es));
    check({ctx, ".walk"}, 32'(ped_walk), 32'(ew));
    check({ctx, ".phase"}, 32'(phase), 32'(m_st));
  endtask

  initial begin
    int fault_left, s_hold;
    bit s, p, en, f;
    fault_left = 0; s_hold = 0;
    rst = 1'b1; enable = 1'b1; side_req = 1'b0; ped_req = 1'b0; fault = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.main", 32'(main_rag), 32'h4);
    check("reset.side", 32'(side_rag), 32'h4);
    check("reset.walk", 32'(ped_walk), 32'h0);
    check("reset.phase", 32'(phase), 32'h0);
    rst = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        compare_all("run");
      end
      if (cyc == 60) check("idle.hold_green", 32'(phase), 32'd2);
      rst = 1'b0;
      if (cyc % 700 == 350) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        continue;
      end
      if (cyc < 60) begin
        s = 0; p = 0; en = 1; f = 0;
      end else begin
        en = ($urandom_range(0, 9) != 0);
        if (fault_left == 0 && $urandom_range(0, 149) == 0) fault_left = $urandom_range(1, 8);
        f = (fault_left > 0);
        if (fault_left > 0) fault_left--;
        if (s_hold == 0 && $urandom_range(0, 39) == 0) s_hold = $urandom_range(2, 10);
        s = (s_hold > 0) || ($urandom_range(0, 11) == 0);
        if (s_hold > 0) s_hold--;
        p = ($urandom_range(0, 15) == 0);
      end
      side_req = s; ped_req = p; enable = en; fault = f;
      model_step(s, p, en, f);
    end
    @(negedge clk);
    compare_all("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
